// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write-side FIFO: the user pushes words and the FSM
// pops them into start/data/parity/stop frames on a registered serial line.
module uart_tx_fifo #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BAUD_RATE  = 115200,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_CHECK      = 0,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_FIFO_DEPTH      = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_user_tx_valid,
  input  logic [P_UART_DATA_WIDTH-1:0]      i_user_tx_data,
  output logic                              o_user_tx_ready,
  output logic                              o_uart_tx,
  output logic                              o_tx_busy,
  output logic [$clog2(P_FIFO_DEPTH):0]     o_fifo_level
);

  localparam int DIV    = P_SYSTEM_CLK / P_UART_BAUD_RATE;
  localparam int BAUD_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PTR_W  = $clog2(P_FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int W      = P_UART_DATA_WIDTH;

  localparam logic [BAUD_W-1:0] DIV_M1     = BAUD_W'(DIV - 1);
  localparam logic [3:0]        DATA_LAST  = 4'(P_UART_DATA_WIDTH - 1);
  localparam logic [3:0]        STOP_LAST  = 4'(P_UART_STOP_WIDTH - 1);
  localparam logic [LVL_W-1:0]  DEPTH_L    = LVL_W'(P_FIFO_DEPTH);
  localparam bit                HAS_PARITY = (P_UART_CHECK != 0);

  if (DIV < 2 || P_UART_DATA_WIDTH < 5 || P_UART_DATA_WIDTH > 9 ||
      P_UART_CHECK < 0 || P_UART_CHECK > 2 ||
      P_UART_STOP_WIDTH < 1 || P_UART_STOP_WIDTH > 2 ||
      P_FIFO_DEPTH < 2 || (P_FIFO_DEPTH & (P_FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [3:0]          bit_q, bit_d;
  logic [W-1:0]        shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                tx_q, tx_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [W-1:0]        mem_q [P_FIFO_DEPTH];

  logic         wr_en;
  logic         pop;
  logic         load;
  logic         fifo_nonempty;
  logic         baud_done;
  logic [W-1:0] rd_data;

  assign o_user_tx_ready = (level_q < DEPTH_L);
  assign wr_en           = i_user_tx_valid && o_user_tx_ready;
  // Emptiness uses the registered level, so a word written this edge is popped next edge at the earliest.
  assign fifo_nonempty   = (level_q != '0);
  assign rd_data         = mem_q[rd_ptr_q];
  assign baud_done       = (baud_q == DIV_M1);

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    load     = 1'b0;
    pop      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        load = fifo_nonempty;
      end
      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (HAS_PARITY) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_done) begin
          state_d = S_STOP;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (fifo_nonempty) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared frame launch from IDLE or straight out of the last stop bit.
    if (load) begin
      pop      = 1'b1;
      state_d  = S_START;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = rd_data;
      parity_d = (P_UART_CHECK == 2) ? ^rd_data : ~^rd_data;
      tx_d     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and level decide what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_user_tx_data;
  end

  assign o_uart_tx    = tx_q;
  assign o_tx_busy    = (state_q != S_IDLE);
  assign o_fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four parameterisations at DIV=10, checked
// cycle by cycle against hand-built frame bit patterns.
module tb_uart_tx_fifo;

  localparam int SYS  = 1_000_000;
  localparam int BAUD = 100_000;
  localparam int DIV  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid_w;
  logic [7:0] data0, data1, data2;
  logic [6:0] data3;
  logic [3:0] ready_w, tx_w, busy_w;
  logic [4:0] lvl0, lvl1, lvl2, lvl3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.P_SYSTEM_CLK(SYS), .P_UART_BAUD_RATE(BAUD), .P_UART_DATA_WIDTH(8),
                 .P_UART_CHECK(0), .P_UART_STOP_WIDTH(1), .P_FIFO_DEPTH(16)) u_plain (
    .i_clk(clk), .i_rst(rst), .i_user_tx_valid(valid_w[0]), .i_user_tx_data(data0),
    .o_user_tx_ready(ready_w[0]), .o_uart_tx(tx_w[0]), .o_tx_busy(busy_w[0]), .o_fifo_level(lvl0));

  uart_tx_fifo #(.P_SYSTEM_CLK(SYS), .P_UART_BAUD_RATE(BAUD), .P_UART_DATA_WIDTH(8),
                 .P_UART_CHECK(1), .P_UART_STOP_WIDTH(1), .P_FIFO_DEPTH(16)) u_odd (
    .i_clk(clk), .i_rst(rst), .i_user_tx_valid(valid_w[1]), .i_user_tx_data(data1),
    .o_user_tx_ready(ready_w[1]), .o_uart_tx(tx_w[1]), .o_tx_busy(busy_w[1]), .o_fifo_level(lvl1));

  uart_tx_fifo #(.P_SYSTEM_CLK(SYS), .P_UART_BAUD_RATE(BAUD), .P_UART_DATA_WIDTH(8),
                 .P_UART_CHECK(2), .P_UART_STOP_WIDTH(1), .P_FIFO_DEPTH(16)) u_even (
    .i_clk(clk), .i_rst(rst), .i_user_tx_valid(valid_w[2]), .i_user_tx_data(data2),
    .o_user_tx_ready(ready_w[2]), .o_uart_tx(tx_w[2]), .o_tx_busy(busy_w[2]), .o_fifo_level(lvl2));

  // 7 data bits, even parity, 2 stop bits: an 11-bit, 110-cycle frame.
  uart_tx_fifo #(.P_SYSTEM_CLK(SYS), .P_UART_BAUD_RATE(BAUD), .P_UART_DATA_WIDTH(7),
                 .P_UART_CHECK(2), .P_UART_STOP_WIDTH(2), .P_FIFO_DEPTH(16)) u_w7 (
    .i_clk(clk), .i_rst(rst), .i_user_tx_valid(valid_w[3]), .i_user_tx_data(data3),
    .o_user_tx_ready(ready_w[3]), .o_uart_tx(tx_w[3]), .o_tx_busy(busy_w[3]), .o_fifo_level(lvl3));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call just after the start-bit edge; bit i of exp is the i-th line bit.
  task automatic check_frame(input string tag, input int inst, input logic [15:0] exp,
                             input int nbits);
    logic [9:0] obs;
    int busy_cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < DIV; c++) begin
        obs[c] = tx_w[inst];
        busy_cnt += int'(busy_w[inst]);
        tick();
      end
      check($sformatf("%s_bit%0d", tag, b), obs, exp[b] ? 10'h3FF : 10'h000);
    end
    check({tag, "_busy_cycles"}, busy_cnt, nbits * DIV);
    check({tag, "_idle_line"}, tx_w[inst], 1'b1);
    check({tag, "_idle_busy"}, busy_w[inst], 1'b0);
  endtask

  function automatic logic [7:0] word_of(input int i);
    return 8'(i * 29 + 17);
  endfunction

  logic line_buf [1700];
  logic [99:0] obs100, exp100;
  logic [9:0]  fb;
  int idx, peak, busy_total;
  logic full_ready_bad, r;

  initial begin
    rst = 1'b1;
    valid_w = '0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
    tick();
    tick();
    check("rst_line", tx_w, 4'hF);
    check("rst_busy", busy_w, 4'h0);
    check("rst_ready", ready_w, 4'hF);
    check("rst_level", {lvl0, lvl1, lvl2, lvl3}, 20'h0);
    rst = 1'b0;
    tick();
    tick();

    // 0xA5, no parity, 1 stop bit.
    data0 = 8'hA5; valid_w[0] = 1'b1;
    tick();
    valid_w[0] = 1'b0;
    check("a5_level_after_write", lvl0, 5'd1);
    check("a5_line_at_write", tx_w[0], 1'b1);
    check("a5_busy_at_write", busy_w[0], 1'b0);
    tick();
    check("a5_level_after_pop", lvl0, 5'd0);
    check_frame("a5", 0, {1'b1, 8'hA5, 1'b0}, 10);

    // 0x07 with odd parity (bit 0) and even parity (bit 1).
    data1 = 8'h07; valid_w[1] = 1'b1;
    tick();
    valid_w[1] = 1'b0;
    tick();
    check_frame("odd07", 1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    data2 = 8'h07; valid_w[2] = 1'b1;
    tick();
    valid_w[2] = 1'b0;
    tick();
    check_frame("even07", 2, {1'b1, 1'b1, 8'h07, 1'b0}, 11);

    // 7 data bits, even parity (0x55 has four ones -> 0), two stop bits.
    data3 = 7'h55; valid_w[3] = 1'b1;
    tick();
    valid_w[3] = 1'b0;
    tick();
    check_frame("w7s2", 3, {2'b11, 1'b0, 7'h55, 1'b0}, 11);

    // Valid held 20 cycles: 17 accepted, 17 frames back-to-back.
    idx = 0; peak = 0; busy_total = 0; full_ready_bad = 1'b0;
    data0 = word_of(0); valid_w[0] = 1'b1;
    fork
      begin
        for (int c = 0; c < 20; c++) begin
          r = ready_w[0];
          tick();
          if (r) begin
            idx++;
            data0 = word_of(idx);
          end
          if (int'(lvl0) > peak) peak = int'(lvl0);
          if (lvl0 == 5'd16 && ready_w[0]) full_ready_bad = 1'b1;
        end
        valid_w[0] = 1'b0;
        check("burst_accepted", idx, 17);
        check("burst_peak_level", peak, 16);
        check("burst_full_level", lvl0, 5'd16);
        check("burst_full_ready", ready_w[0], 1'b0);
        check("burst_ready_low_while_full", full_ready_bad, 1'b0);
      end
      begin
        tick();
        tick();
        for (int i = 0; i < 1700; i++) begin
          line_buf[i] = tx_w[0];
          busy_total += int'(busy_w[0]);
          tick();
        end
      end
    join
    check("burst_busy_cycles", busy_total, 1700);
    check("burst_idle_line", tx_w[0], 1'b1);
    check("burst_idle_busy", busy_w[0], 1'b0);
    check("burst_final_level", lvl0, 5'd0);
    for (int k = 0; k < 17; k++) begin
      fb = {1'b1, word_of(k), 1'b0};
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < DIV; c++) begin
          exp100[b * DIV + c] = fb[b];
          obs100[b * DIV + c] = line_buf[k * 100 + b * DIV + c];
        end
      end
      check($sformatf("burst_frame%0d", k), obs100, exp100);
    end

    // Reset mid-frame: 6 writes (first pops at once, 5 stay queued).
    tick();
    valid_w[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data0 = (i == 0) ? 8'hF0 : word_of(i + 40);
      tick();
    end
    valid_w[0] = 1'b0;
    check("rstmid_level_queued", lvl0, 5'd5);
    repeat (36) tick();
    check("rstmid_line_before", tx_w[0], 1'b0);
    check("rstmid_busy_before", busy_w[0], 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("rstmid_line_async", tx_w[0], 1'b1);
    check("rstmid_level_async", lvl0, 5'd0);
    check("rstmid_busy_async", busy_w[0], 1'b0);
    check("rstmid_ready_async", ready_w[0], 1'b1);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rstmid_discard_line", tx_w[0], 1'b1);
    check("rstmid_discard_busy", busy_w[0], 1'b0);
    check("rstmid_discard_level", lvl0, 5'd0);
    data0 = 8'h3C; valid_w[0] = 1'b1;
    tick();
    valid_w[0] = 1'b0;
    tick();
    check_frame("post_rst_3c", 0, {1'b1, 8'h3C, 1'b0}, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter P_SYSTEM_CLK, default 50_000_000, which is the i_clk frequency in Hz.
REQ-002 The block SHALL have parameter P_UART_BAUD_RATE, default 115200, which is the line bit rate in bits per second.
REQ-003 The block SHALL have parameter P_UART_DATA_WIDTH, default 8, which is the number of data bits per frame (legal range 5..9).
REQ-004 The block SHALL have parameter P_UART_CHECK, default 0, which selects parity: 0 = none, 1 = odd, 2 = even.
REQ-005 The block SHALL have parameter P_UART_STOP_WIDTH, default 1, which is the number of stop bits (1 or 2).
REQ-006 The block SHALL have parameter P_FIFO_DEPTH, default 16, which is the transmit FIFO depth in words (power of 2, at least 2).
REQ-007 The block SHALL have port i_clk, input, 1 bit: the system clock; all logic uses the rising edge.
REQ-008 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 The block SHALL have port i_user_tx_valid, input, 1 bit: the user word is valid.
REQ-010 The block SHALL have port i_user_tx_data, input, P_UART_DATA_WIDTH bits: the user word.
REQ-011 The block SHALL have port o_user_tx_ready, output, 1 bit: the FIFO can accept a word.
REQ-012 The block SHALL have port o_uart_tx, output, 1 bit: the serial line, registered, idle high.
REQ-013 The block SHALL have port o_tx_busy, output, 1 bit: a frame is in progress.
REQ-014 The block SHALL have port o_fifo_level, output, $clog2(P_FIFO_DEPTH)+1 bits: the number of words currently stored.

Function
REQ-015 Bit period DIV SHALL be P_SYSTEM_CLK/P_UART_BAUD_RATE (integer truncation); elaboration SHALL fail if DIV < 2 or if any parameter is outside its legal range.
REQ-016 o_user_tx_ready SHALL equal (o_fifo_level < P_FIFO_DEPTH); a word is written on every edge where i_user_tx_valid and o_user_tx_ready are both 1.
REQ-017 Writes while the FIFO is full SHALL be ignored, and the FIFO contents SHALL remain unchanged.
REQ-018 The FSM states SHALL be IDLE, START, DATA, PARITY and STOP; PARITY SHALL be skipped when P_UART_CHECK=0.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop one word into the shift register on the next edge, enter START, and drive o_uart_tx=0 from that edge.
REQ-020 Every line bit SHALL be held for exactly DIV cycles, using a baud counter that is cleared on each state entry.
REQ-021 Data bits SHALL be sent LSB first, P_UART_DATA_WIDTH bits, using a bit index counter.
REQ-022 The parity bit SHALL be XOR of the data bits for even parity, and its inverse for odd parity, computed from the popped word before shifting.
REQ-023 In STOP, o_uart_tx SHALL be 1 for P_UART_STOP_WIDTH*DIV cycles.
REQ-024 At the end of STOP, with the FIFO non-empty, the FSM SHALL go directly to START with the next word, leaving no idle cycle between frames; otherwise it SHALL go to IDLE.
REQ-025 Frame length SHALL be exactly (1 + P_UART_DATA_WIDTH + (P_UART_CHECK!=0) + P_UART_STOP_WIDTH) * DIV cycles.
REQ-026 o_tx_busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-027 On a write and a pop in the same cycle, o_fifo_level SHALL be unchanged; a write into an empty FIFO SHALL NOT be popped in the same cycle.
REQ-028 FIFO pointers SHALL wrap modulo P_FIFO_DEPTH; o_fifo_level SHALL range 0..P_FIFO_DEPTH.
REQ-029 The latency from a write edge into an empty FIFO, with the FSM idle, to the start-bit edge SHALL be 1 cycle.

Reset
REQ-030 While i_rst=1, the block SHALL hold o_uart_tx=1, o_tx_busy=0, o_user_tx_ready=1 and o_fifo_level=0, with the FSM in IDLE and the baud and bit counters and FIFO pointers at 0.
REQ-031 Reset during a frame SHALL take effect asynchronously: the line SHALL go high immediately, and the partial frame and all FIFO contents SHALL be discarded.

Verification (bench parameters: P_SYSTEM_CLK=1_000_000, P_UART_BAUD_RATE=100_000, so DIV=10, P_FIFO_DEPTH=16 unless noted)
REQ-032 Bench scenario: with no parity and 1 stop bit, write 0xA5 -> line bits 0,1,0,1,0,0,1,0,1,1, each 10 cycles long, o_tx_busy high for 100 cycles, and the start bit 1 cycle after the write.
REQ-033 Bench scenario: with odd parity, write 0x07 -> parity bit 0; with even parity, write 0x07 -> parity bit 1; the frame is 110 cycles long.
REQ-034 Bench scenario: hold valid for 20 consecutive cycles while idle -> 17 words accepted, o_fifo_level peaks at 16, ready is low while full, all 17 frames are sent back-to-back with no idle gap, and all bytes arrive in order.
REQ-035 Bench scenario: with P_UART_DATA_WIDTH=7 and P_UART_STOP_WIDTH=2, write 0x55 -> an 11-bit frame of 110 cycles whose last 20 cycles are high.
REQ-036 Bench scenario: assert reset during data bit 3 with 5 words queued -> line high in the same cycle and level 0; after release, a write of 0x3C is transmitted correctly.
